// File: rtl/rd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rd_pkg: shared types and constants for rd_burst_ctrl             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int c_hex_state_lsb = 29;
  localparam int c_hex_carry_bit = 28;
  localparam int c_hex_csum_w    = 24;

  localparam logic [31:0] c_word_bytes = 32'd4;

endpackage : rd_pkg
`default_nettype wire

// File: rtl/rd_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rd_burst_ctrl: Avalon-MM burst reader with running checksum      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rd_burst_ctrl
  import rd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  output logic        done,
  output logic [31:0] tohexled,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam logic [15:0] c_num_words = 16'(NUM_WORDS);

  state_e      r_state;
  state_e      w_next;
  logic        r_ready_q;
  logic [31:0] r_addr;
  logic [15:0] r_count;
  logic [31:0] r_csum;
  logic        r_carry;
  logic        r_done;
  logic        r_read;
  logic [31:0] r_hex;
  logic        w_done;
  logic        w_read;
  logic        w_start;
  logic        w_take;
  logic [32:0] w_sum;
  logic [31:0] w_hex;

  assign w_start = (r_state == ST_IDLE) && ready && !r_ready_q;
  assign w_take  = (r_state == ST_WAIT) && avm_readdatavalid;
  assign w_sum   = {1'b0, r_csum} + {1'b0, avm_readdata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ:  if (!avm_waitrequest) w_next = ST_WAIT;
      ST_WAIT: if (avm_readdatavalid) w_next = ST_NEXT;
      ST_NEXT: w_next = (r_count == c_num_words) ? ST_DONE : ST_REQ;
      ST_DONE: if (!ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    w_read = (w_next == ST_REQ);
    w_done = (w_next == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_read <= w_read;
      r_done <= w_done;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_q <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_count   <= '0;
      r_csum    <= '0;
      r_carry   <= 1'b0;
    end else begin
      r_ready_q <= ready;
      if (w_start) begin
        r_addr  <= BASE_ADDR;
        r_count <= '0;
        r_csum  <= '0;
        r_carry <= 1'b0;
      end else if (w_take) begin
        r_csum  <= w_sum[31:0];
        r_carry <= r_carry | w_sum[32];
        r_count <= r_count + 16'd1;
      end else if ((r_state == ST_NEXT) && (r_count != c_num_words)) begin
        r_addr <= r_addr + c_word_bytes;
      end
    end
  end

  always_comb begin
    w_hex = '0;
    w_hex[c_hex_state_lsb +: 3]      = r_state;
    w_hex[c_hex_carry_bit]           = r_carry;
    w_hex[c_hex_csum_w-1:0]          = r_csum[c_hex_csum_w-1:0];
  end

  // Display word trails the state/checksum by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex <= '0;
    end else begin
      r_hex <= w_hex;
    end
  end

  assign done        = r_done;
  assign avm_read    = r_read;
  assign avm_address = r_addr;
  assign tohexled    = r_hex;

endmodule : rd_burst_ctrl
`default_nettype wire

// File: tb/tb_rd_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rd_burst_ctrl: directed self-checking bench for rd_burst_ctrl |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rd_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ready;
  logic        done;
  logic [31:0] tohexled;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  int          n_chk  = 0;
  int          n_pass = 0;

  logic [31:0] mem [0:3];
  logic [31:0] acc_addr [0:63];
  int          acc_cnt = 0;
  int          stall_left = 0;
  bit          spur_idle = 0;
  bit          spur_req = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0;

  rd_burst_ctrl #(
    .BASE_ADDR(32'h0000_0100),
    .NUM_WORDS(4)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ready            (ready),
    .done             (done),
    .tohexled         (tohexled),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  // Slave model: one outstanding read, data returned the cycle after acceptance.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (!reset_n) pend = 0;
    if (pend) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = pend_data;
      pend              = 0;
    end else if (spur_idle && !avm_read) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h55;
      spur_idle         = 0;
    end
    if (avm_read) begin
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left      = stall_left - 1;
      end else begin
        avm_waitrequest = 1'b0;
        if (spur_req) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = 32'h55;
          spur_req          = 0;
        end
        pend      = 1;
        pend_data = mem[(avm_address - 32'h100) >> 2];
        if (acc_cnt < 64) acc_addr[acc_cnt] = avm_address;
        acc_cnt = acc_cnt + 1;
      end
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Raises ready and counts cycles until done; lat=0 on timeout.
  task automatic run(output int lat, output int stable);
    lat    = 0;
    stable = 0;
    ready  = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (avm_read && avm_address == 32'h100) stable++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic set_mem(input logic [31:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  int lat, stable, base, snap;
  bit hit;

  initial begin
    reset_n = 1'b0;
    ready   = 1'b0;
    set_mem(32'd1, 32'd2, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", avm_address, 32'h100);
    check("rst_hex", tohexled, 32'd0);
    reset_n = 1'b1;

    spur_idle = 1;
    repeat (3) @(negedge clk);
    check("idle_spur_hex", tohexled, 32'd0);
    check("idle_read", {31'd0, avm_read}, 32'd0);

    base = acc_cnt;
    run(lat, stable);
    check("basic_lat", lat, 32'd13);
    check("basic_nacc", acc_cnt - base, 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("basic_addr%0d", i), acc_addr[base + i], 32'h100 + 32'(4 * i));
    @(negedge clk);
    check("basic_hex", tohexled, 32'h8000_000A);
    ready = 1'b0;
    @(negedge clk);
    check("basic_done_fall", {31'd0, done}, 32'd0);

    stall_left = 5;
    spur_req   = 1;
    run(lat, stable);
    check("stall_lat", lat, 32'd18);
    check("stall_stable", stable, 32'd6);
    @(negedge clk);
    check("stall_hex", tohexled, 32'h8000_000A);
    ready = 1'b0;
    @(negedge clk);

    set_mem(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    run(lat, stable);
    check("carry_lat", lat, 32'd13);
    @(negedge clk);
    check("carry_hex", tohexled, 32'h9000_0001);
    snap = acc_cnt;
    repeat (10) @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_norun", acc_cnt - snap, 32'd0);
    check("hold_hex", tohexled, 32'h9000_0001);
    ready = 1'b0;
    @(negedge clk);
    check("hs_done_fall", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("hs_idle_hex", tohexled, 32'h1000_0001);

    set_mem(32'd1, 32'd2, 32'd3, 32'd4);
    run(lat, stable);
    check("rerun_lat", lat, 32'd13);
    @(negedge clk);
    check("rerun_hex", tohexled, 32'h8000_000A);
    ready = 1'b0;
    @(negedge clk);

    base  = acc_cnt;
    ready = 1'b1;
    hit   = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (acc_cnt - base >= 4) begin
        hit = 1;
        break;
      end
    end
    check("mid_reach", {31'd0, hit}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_read", {31'd0, avm_read}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_hex", tohexled, 32'd0);
    check("mid_rst_addr", avm_address, 32'h100);
    ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    snap = acc_cnt;
    repeat (5) @(negedge clk);
    check("post_rst_norun", acc_cnt - snap, 32'd0);
    check("post_rst_hex", tohexled, 32'd0);
    run(lat, stable);
    check("post_rst_lat", lat, 32'd13);
    @(negedge clk);
    check("post_rst_hex_final", tohexled, 32'h8000_000A);
    ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_rd_burst_ctrl
`default_nettype wire

// File: doc/rd_burst_ctrl.md
# rd_burst_ctrl

Avalon-MM read-master controller that sits directly upstream of the board's hex/LED display path. On a start request from the HPS ready PIO (ORed with a push-button at top level), it reads a fixed window of words from SDRAM, accumulates a 32-bit running checksum, and signals completion on the done PIO using a four-phase handshake. It also publishes a 32-bit status word that the top level splits across HEX0–HEX5 and LEDR[7:0].

## Interface
- BASE_ADDR, default 32'h0000_0000: byte address of the first word read; must be word-aligned.
- NUM_WORDS, default 1024: number of 32-bit words per run; legal range 1..65535.
- clk  in  1  system clock, 50 MHz domain.
- reset_n  in  1  reset; one clock, asynchronous assert, active-low.
- ready  in  1  start request; level input, already synchronous to clk.
- done  out  1  run complete; held until ready is low.
- tohexled  out  32  status word:
  - [31:29] state code
  - [28] sticky checksum carry
  - [27:24] 0
  - [23:0] checksum[23:0]
- avm_address  out  32  Avalon byte address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.

## Operation
- States and codes: IDLE=0, REQ=1, WAIT=2, NEXT=3, DONE=4.
- IDLE:
  - ready_q registers ready every cycle.
  - A rising edge (ready=1, ready_q=0) moves to REQ.
  - On that transition: checksum=0, carry=0, word count=0, address=BASE_ADDR.
  - A level-high ready left over from a previous run does not restart.
- REQ: avm_read=1 with avm_address stable. Stay while avm_waitrequest=1; go to WAIT on the first cycle avm_waitrequest=0.
- WAIT:
  - avm_read=0.
  - On avm_readdatavalid=1: {carry_out, checksum} = checksum + avm_readdata (33-bit add); carry |= carry_out; count += 1; go to NEXT.
- NEXT:
  - If count==NUM_WORDS, go to DONE.
  - Otherwise address += 4 and go to REQ.
- DONE: done=1. Stay while ready=1. When ready=0, go to IDLE and drop done.
- Only one read is outstanding at a time.
- avm_readdatavalid outside WAIT is ignored and does not change the checksum or count.
- A ready drop mid-run does not abort; the run completes, and DONE exits on its first cycle if ready is already low.
- Address arithmetic is 32-bit modulo 2^32; wrap past 32'hFFFF_FFFC is not flagged.
- Checksum is modulo 2^32; only bits [23:0] are exported.

## Timing
- Reset (async, any state, including mid-transfer):
  - state=IDLE, ready_q=0.
  - done=0, avm_read=0, avm_address=BASE_ADDR, tohexled=0.
  - Checksum, carry and count are cleared.
- All outputs are registered. tohexled updates the cycle after the state or checksum changes.
- Start latency: avm_read rises 1 cycle after the ready rising edge is sampled.
- Per word, with waitrequest=0 and readdatavalid latency L≥1: REQ 1 + WAIT L + NEXT 1 = L+2 cycles.
- done rises 2 cycles after the final readdatavalid (NEXT, then registered DONE).
- done falls 1 cycle after ready is sampled low in DONE.
- A new rising edge is recognised at the earliest 1 cycle after re-entering IDLE.
- Simultaneous avm_waitrequest deassert and avm_readdatavalid in REQ: the readdatavalid is ignored, because a compliant slave cannot return data before accepting the command.

## Structure
- Shared package rd_pkg:
  - state enum with encodings 0..4.
  - tohexled field offsets.
  - Avalon word-size constant (4 bytes).
- No sub-module. The single FSM plus datapath registers (address, count, checksum, carry, ready_q) fits in one module.
- The top level instantiates display_hex on tohexled[23:0] and drives LEDR from tohexled[31:24].

## Test plan
- Reset mid-run: assert reset_n=0 in WAIT after 3 words → next cycle avm_read=0, done=0, tohexled=0. After release, IDLE is held until a new ready edge.
- Basic run: NUM_WORDS=4, BASE=0x100, memory words 1,2,3,4, waitrequest=0, L=1:
  - addresses 0x100, 0x104, 0x108, 0x10C issued.
  - done high at cycle 13 after start edge.
  - tohexled[23:0]=0x00000A, [31:29]=4.
- Stall: waitrequest held high 5 cycles on word 0 → avm_read and address stay stable for 6 cycles; the final checksum is unchanged from the basic run.
- Carry: two words 0xFFFF_FFFF and 0x0000_0002 → checksum 0x0000_0001, tohexled[28]=1.
- Handshake:
  - ready held high after done → stays in DONE, no second run.
  - ready low → done=0 next cycle.
  - ready high again → new run starts, with checksum cleared.
- Spurious data: a readdatavalid pulse with data 0x55 while in IDLE, and another in REQ → checksum and count are unaffected.
